// File: rtl/charbuf_console_writer_if.sv
// Byte-stream input and character-buffer write port of the console writer.
// The writer sits on the slave side; the byte source and buffer observer use master.
interface charbuf_console_writer_if;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        wr_ce;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    output char_data, char_valid,
    input  char_ready, wr_ce, wr_addr, wr_data
  );

  modport slave (
    input  char_data, char_valid,
    output char_ready, wr_ce, wr_addr, wr_data
  );
endinterface

// File: rtl/charbuf_console_writer.sv
// Turns a byte stream into character-buffer write cycles, tracking a text cursor
// and scrolling by rotating the row offset the renderer adds to its row address.
module charbuf_console_writer #(
  parameter int unsigned COLS           = 64,
  parameter int unsigned ROWS           = 64,
  parameter logic [7:0]  BLANK          = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  charbuf_console_writer_if.slave  bus,
  output logic [5:0]               row_offset,
  output logic [5:0]               cursor_col,
  output logic [5:0]               cursor_row,
  output logic                     busy
);

  // state    | meaning
  // IDLE     | accepting bytes; char_ready rises the cycle after entry
  // CLR_LINE | blanking the newly exposed bottom row, one cell per cycle
  // CLR_ALL  | blanking the whole buffer row-major from {0,0}
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
  localparam logic [6:0] ROWS_W  = 7'(ROWS);

  state_t      state;
  logic [5:0]  clr_row;
  logic [5:0]  clr_col;
  logic [6:0]  row_sum;
  logic [5:0]  phys_row;
  logic [5:0]  offset_inc;
  logic [7:0]  d;
  logic        accept;
  logic        is_print;
  logic        at_bottom;
  logic        do_nl;

  always_comb begin
    row_sum    = {1'b0, cursor_row} + {1'b0, row_offset};
    phys_row   = (row_sum >= ROWS_W) ? 6'(row_sum - ROWS_W) : row_sum[5:0];
    offset_inc = (row_offset == ROW_MAX) ? 6'd0 : row_offset + 6'd1;
    d          = bus.char_data;
    accept     = (state == IDLE) && bus.char_valid && bus.char_ready;
    is_print   = (d >= 8'h20) && (d != 8'h7F);
    at_bottom  = (cursor_row == ROW_MAX);
    do_nl      = accept && ((is_print && (cursor_col == COL_MAX)) || (d == 8'h0A));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      clr_row        <= '0;
      clr_col        <= '0;
      row_offset     <= '0;
      cursor_col     <= '0;
      cursor_row     <= '0;
      busy           <= 1'b0;
      bus.char_ready <= 1'b0;
      bus.wr_ce      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
    end else begin
      bus.wr_ce <= 1'b0;
      unique case (state)
        IDLE: begin
          busy           <= 1'b0;
          bus.char_ready <= 1'b1;
          if (accept) begin
            if (is_print) begin
              bus.wr_ce   <= 1'b1;
              bus.wr_addr <= {phys_row, cursor_col};
              bus.wr_data <= d;
              cursor_col  <= (cursor_col == COL_MAX) ? 6'd0 : cursor_col + 6'd1;
            end else if (d == 8'h0D) begin
              cursor_col <= 6'd0;
            end else if (d == 8'h08) begin
              if (cursor_col != 6'd0) begin
                cursor_col  <= cursor_col - 6'd1;
                bus.wr_ce   <= 1'b1;
                bus.wr_addr <= {phys_row, cursor_col - 6'd1};
                bus.wr_data <= BLANK;
              end
            end else if (d == 8'h0C) begin
              cursor_col     <= 6'd0;
              cursor_row     <= 6'd0;
              row_offset     <= 6'd0;
              clr_row        <= 6'd0;
              clr_col        <= 6'd0;
              state          <= CLR_ALL;
              bus.char_ready <= 1'b0;
            end
          end
          // The old top row becomes the new bottom row once the offset advances.
          if (do_nl) begin
            if (!at_bottom) begin
              cursor_row <= cursor_row + 6'd1;
            end else begin
              row_offset     <= offset_inc;
              clr_row        <= row_offset;
              clr_col        <= 6'd0;
              state          <= CLR_LINE;
              bus.char_ready <= 1'b0;
            end
          end
        end
        CLR_LINE: begin
          busy           <= 1'b1;
          bus.char_ready <= 1'b0;
          bus.wr_ce      <= 1'b1;
          bus.wr_addr    <= {clr_row, clr_col};
          bus.wr_data    <= BLANK;
          if (clr_col == COL_MAX) begin
            clr_col <= 6'd0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + 6'd1;
          end
        end
        CLR_ALL: begin
          busy           <= 1'b1;
          bus.char_ready <= 1'b0;
          bus.wr_ce      <= 1'b1;
          bus.wr_addr    <= {clr_row, clr_col};
          bus.wr_data    <= BLANK;
          if (clr_col == COL_MAX) begin
            clr_col <= 6'd0;
            if (clr_row == ROW_MAX) begin
              clr_row <= 6'd0;
              state   <= IDLE;
            end else begin
              clr_row <= clr_row + 6'd1;
            end
          end else begin
            clr_col <= clr_col + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_charbuf_console_writer.sv
// Directed bench for charbuf_console_writer: logs every buffer write and checks
// clears, printable writes, control codes, scrolling and reset abort.
module tb_charbuf_console_writer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] row_offset;
  logic [5:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [11:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];

  charbuf_console_writer_if bus_if ();

  charbuf_console_writer #(
    .COLS(64), .ROWS(64), .BLANK(8'h20), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if),
    .row_offset(row_offset),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_if.wr_ce === 1'b1) begin
      wq_addr.push_back(bus_if.wr_addr);
      wq_data.push_back(bus_if.wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is just after a falling edge; returns just after the falling edge following the transfer.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus_if.char_data  = b;
    bus_if.char_valid = 1'b1;
    while (bus_if.char_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_wait_expired", 32'(n >= 6000), 32'd0);
    @(negedge clk);
    #1;
    bus_if.char_valid = 1'b0;
  endtask

  task automatic run_clear(input string tag);
    int base, n, busy_n, rdy_bad, cell_bad;
    base = wq_addr.size();
    n = 0; busy_n = 0; rdy_bad = 0; cell_bad = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (busy === 1'b1) begin
        busy_n++;
        if (bus_if.char_ready !== 1'b0) rdy_bad++;
      end
    end while (bus_if.char_ready !== 1'b1 && n < 6000);
    chk({tag, "_expired"}, 32'(n >= 6000), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd4096);
    chk({tag, "_ready_low"}, 32'(rdy_bad), 32'd0);
    chk({tag, "_writes"}, 32'(wq_addr.size() - base), 32'd4096);
    for (int k = 0; k < wq_addr.size() - base && k < 4096; k++)
      if (wq_addr[base+k] !== 12'(k) || wq_data[base+k] !== 8'h20) cell_bad++;
    chk({tag, "_cells"}, 32'(cell_bad), 32'd0);
  endtask

  initial begin
    int base, n, busy_n, rdy_bad, bad, acc;
    bus_if.char_valid = 1'b0;
    bus_if.char_data  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus_if.char_ready), 32'd0);
    chk("rst_wr_ce", 32'(bus_if.wr_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(bus_if.wr_addr), 32'd0);
    chk("rst_offset", 32'(row_offset), 32'd0);
    chk("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);

    // Power-up clear
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_clear("init_clear");
    chk("init_cursor", 32'({cursor_row, cursor_col}), 32'd0);

    // "AB" back-to-back
    base = wq_addr.size();
    send(8'h41);
    send(8'h42);
    chk("ab_count", 32'(wq_addr.size() - base), 32'd2);
    chk("ab_addr0", 32'(wq_addr[base]), 32'h000);
    chk("ab_data0", 32'(wq_data[base]), 32'h41);
    chk("ab_addr1", 32'(wq_addr[base+1]), 32'h001);
    chk("ab_data1", 32'(wq_data[base+1]), 32'h42);
    chk("ab_gap", 32'(wq_cyc[base+1] - wq_cyc[base]), 32'd1);
    chk("ab_col", 32'(cursor_col), 32'd2);

    // CR then BS at column 0
    base = wq_addr.size();
    send(8'h0D);
    send(8'h08);
    chk("crbs_writes", 32'(wq_addr.size() - base), 32'd0);
    chk("crbs_col", 32'(cursor_col), 32'd0);

    // BS at column 5
    for (int i = 0; i < 5; i++) send(8'h78);
    chk("bs_pre_col", 32'(cursor_col), 32'd5);
    base = wq_addr.size();
    send(8'h08);
    chk("bs_col", 32'(cursor_col), 32'd4);
    chk("bs_writes", 32'(wq_addr.size() - base), 32'd1);
    chk("bs_addr", 32'(wq_addr[base]), 32'h004);
    chk("bs_data", 32'(wq_data[base]), 32'h20);

    // 63 line feeds reach the bottom row without writes or scrolling
    base = wq_addr.size();
    for (int i = 0; i < 63; i++) send(8'h0A);
    chk("lf_writes", 32'(wq_addr.size() - base), 32'd0);
    chk("lf_row", 32'(cursor_row), 32'd63);
    chk("lf_col", 32'(cursor_col), 32'd4);
    chk("lf_offset", 32'(row_offset), 32'd0);
    send(8'h0D);

    // A full row at the bottom wraps, scrolls and blanks physical row 0
    base = wq_addr.size();
    for (int i = 0; i < 64; i++) send(8'h61 + 8'(i % 26));
    n = 0; busy_n = 0; rdy_bad = 0;
    while (bus_if.char_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
      if (busy === 1'b1) begin
        busy_n++;
        if (bus_if.char_ready !== 1'b0) rdy_bad++;
      end
    end
    chk("wrap_expired", 32'(n >= 500), 32'd0);
    chk("wrap_busy_cycles", 32'(busy_n), 32'd64);
    chk("wrap_ready_low", 32'(rdy_bad), 32'd0);
    chk("wrap_writes", 32'(wq_addr.size() - base), 32'd128);
    bad = 0;
    for (int i = 0; i < 64 && base + 64 + i < wq_addr.size(); i++) begin
      if (wq_addr[base+i] !== 12'(32'hFC0 + i) || wq_data[base+i] !== 8'h61 + 8'(i % 26)) bad++;
      if (wq_addr[base+64+i] !== 12'(i) || wq_data[base+64+i] !== 8'h20) bad++;
    end
    chk("wrap_cells", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k + 1 < wq_addr.size() - base; k++)
      if (wq_cyc[base+k+1] - wq_cyc[base+k] != 1) bad++;
    chk("wrap_contiguous", 32'(bad), 32'd0);
    chk("wrap_row", 32'(cursor_row), 32'd63);
    chk("wrap_col", 32'(cursor_col), 32'd0);
    chk("wrap_offset", 32'(row_offset), 32'd1);

    // Bottom logical row now maps to physical row 0
    base = wq_addr.size();
    send(8'h5A);
    chk("scrolled_addr", 32'(wq_addr[base]), 32'h000);
    chk("scrolled_data", 32'(wq_data[base]), 32'h5A);
    chk("scrolled_col", 32'(cursor_col), 32'd1);

    // Form feed, then reset at clear cycle 100
    base = wq_addr.size();
    send(8'h0C);
    chk("ff_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    chk("ff_offset", 32'(row_offset), 32'd0);
    n = 0;
    while (wq_addr.size() - base < 100 && n < 6000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ff_expired", 32'(n >= 6000), 32'd0);
    chk("ff_addr99", 32'(wq_addr[base+99]), 32'd99);
    chk("ff_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_ce", 32'(bus_if.wr_ce), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(bus_if.char_ready), 32'd0);
    chk("abort_addr", 32'(bus_if.wr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_clear("restart_clear");

    // Ignored control bytes are consumed one per cycle
    send(8'h51);
    base = wq_addr.size();
    acc = 0;
    bus_if.char_data  = 8'h07;
    bus_if.char_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) bus_if.char_data = 8'h7F;
      @(negedge clk);
      #1;
      if (bus_if.char_ready === 1'b1) acc++;
    end
    bus_if.char_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("ign_ready_cycles", 32'(acc), 32'd10);
    chk("ign_writes", 32'(wq_addr.size() - base), 32'd0);
    chk("ign_cursor", 32'({cursor_row, cursor_col}), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
